// File: rtl/movavg_stream.sv
// Streaming moving sum / truncated average over the last 2**LOG2N accepted samples.
// A running-sum accumulator (add newest, subtract evicted) keeps adder cost independent of depth.
module movavg_stream #(
    parameter int W     = 64,
    parameter int LOG2N = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [W-1:0]         din,
    output logic                 out_valid,
    output logic [W+LOG2N-1:0]   dsum,
    output logic [W-1:0]         davg,
    output logic                 primed,
    output logic [LOG2N:0]       fill
);
    localparam int N  = 1 << LOG2N;
    localparam int SW = W + LOG2N;
    localparam logic [LOG2N:0] FILL_MAX = (LOG2N+1)'(N);

    logic [W-1:0]     hist [N];
    logic [LOG2N-1:0] wptr_reg;
    logic [SW-1:0]    sum_reg, sum_next;
    logic [LOG2N:0]   fill_reg, fill_next;
    logic             out_valid_reg, primed_reg;
    logic             accept;

    assign accept = in_valid & ~clr;

    // Modulo arithmetic: any intermediate wrap cancels, so sum_reg is always the exact window sum.
    always_comb begin
        sum_next  = sum_reg + SW'(din) - SW'(hist[wptr_reg]);
        fill_next = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + (LOG2N+1)'(1);
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_entry
            logic [W-1:0] entry_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_reg <= '0;
                end else if (clr) begin
                    entry_reg <= '0;
                end else if (in_valid && (wptr_reg == LOG2N'(gi))) begin
                    entry_reg <= din;
                end
            end
            assign hist[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_reg       <= '0;
            wptr_reg      <= '0;
            fill_reg      <= '0;
            out_valid_reg <= 1'b0;
            primed_reg    <= 1'b0;
        end else if (clr) begin
            sum_reg       <= '0;
            wptr_reg      <= '0;
            fill_reg      <= '0;
            out_valid_reg <= 1'b0;
            primed_reg    <= 1'b0;
        end else if (accept) begin
            sum_reg       <= sum_next;
            wptr_reg      <= wptr_reg + LOG2N'(1);
            fill_reg      <= fill_next;
            out_valid_reg <= 1'b1;
            primed_reg    <= (fill_next == FILL_MAX);
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign dsum      = sum_reg;
    assign davg      = sum_reg[SW-1:LOG2N];
    assign primed    = primed_reg;
    assign fill      = fill_reg;
endmodule

// File: tb/tb_movavg_stream.sv
// Four configurations share one stimulus stream; a queue of accepted samples predicts every output.
module tb_movavg_stream;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] din = '0;
    bit          chk_en = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    logic        a_ov, b_ov, c_ov, d_ov;
    logic [9:0]  a_sum;  logic [7:0]  a_avg;  logic a_pr;  logic [2:0] a_fill;
    logic [65:0] b_sum;  logic [63:0] b_avg;  logic b_pr;  logic [2:0] b_fill;
    logic [64:0] c_sum;  logic [63:0] c_avg;  logic c_pr;  logic [1:0] c_fill;
    logic [68:0] d_sum;  logic [63:0] d_avg;  logic d_pr;  logic [5:0] d_fill;

    movavg_stream #(.W(8), .LOG2N(2)) u_a (.clk(clk), .reset(reset_n), .clr(clr), .in_valid(in_valid),
        .din(din[7:0]), .out_valid(a_ov), .dsum(a_sum), .davg(a_avg), .primed(a_pr), .fill(a_fill));
    movavg_stream #(.W(64), .LOG2N(2)) u_b (.clk(clk), .reset(reset_n), .clr(clr), .in_valid(in_valid),
        .din(din), .out_valid(b_ov), .dsum(b_sum), .davg(b_avg), .primed(b_pr), .fill(b_fill));
    movavg_stream #(.W(64), .LOG2N(1)) u_c (.clk(clk), .reset(reset_n), .clr(clr), .in_valid(in_valid),
        .din(din), .out_valid(c_ov), .dsum(c_sum), .davg(c_avg), .primed(c_pr), .fill(c_fill));
    movavg_stream #(.W(64), .LOG2N(5)) u_d (.clk(clk), .reset(reset_n), .clr(clr), .in_valid(in_valid),
        .din(din), .out_valid(d_ov), .dsum(d_sum), .davg(d_avg), .primed(d_pr), .fill(d_fill));

    // Reference: history of accepted samples since the last reset/clear.
    logic [63:0] hist[$];
    bit          exp_valid;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || clr) begin
            hist.delete();
            exp_valid = 1'b0;
        end else if (in_valid) begin
            hist.push_back(din);
            if (hist.size() > 64) void'(hist.pop_front());
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
    end

    function automatic logic [127:0] exp_sum(int w, int n);
        logic [127:0] s = '0;
        logic [63:0]  mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        int           k = (hist.size() < n) ? hist.size() : n;
        for (int i = 0; i < k; i++) s += 128'(hist[hist.size()-1-i] & mask);
        return s;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(string tag, int w, int l, logic ov, logic [127:0] ds,
                            logic [127:0] da, logic [127:0] fl, logic pr);
        int           n  = 1 << l;
        logic [127:0] s  = exp_sum(w, n);
        int           ef = (hist.size() < n) ? hist.size() : n;
        chk({tag, ".out_valid"}, 128'(ov), 128'(exp_valid));
        chk({tag, ".dsum"}, ds, s);
        chk({tag, ".davg"}, da, s >> l);
        chk({tag, ".fill"}, fl, 128'(ef));
        chk({tag, ".primed"}, 128'(pr), 128'(hist.size() >= n));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst("w8n4",  8,  2, a_ov, 128'(a_sum), 128'(a_avg), 128'(a_fill), a_pr);
            cmp_inst("w64n4", 64, 2, b_ov, 128'(b_sum), 128'(b_avg), 128'(b_fill), b_pr);
            cmp_inst("w64n2", 64, 1, c_ov, 128'(c_sum), 128'(c_avg), 128'(c_fill), c_pr);
            cmp_inst("w64n32", 64, 5, d_ov, 128'(d_sum), 128'(d_avg), 128'(d_fill), d_pr);
            $display("cyc t=%0t v=%0b c=%0b din=%h w8 dsum=%0d fill=%0d", $time, in_valid, clr, din, a_sum, a_fill);
        end
    end

    // Called at a falling edge; returns at the next falling edge with outputs of that sample.
    task automatic step(bit v, bit c, logic [63:0] d);
        in_valid = v;
        clr      = c;
        din      = d;
        @(negedge clk);
    endtask

    int fill_dsum[5] = '{10, 30, 60, 100, 140};
    int fill_davg[5] = '{2, 7, 15, 25, 35};
    int max_dsum[10] = '{255, 510, 765, 1020, 1020, 1020, 765, 510, 255, 0};

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset.dsum", 128'(a_sum), 128'd0);
        chk("reset.fill", 128'(a_fill), 128'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 64'((i + 1) * 10));
            chk($sformatf("fill%0d.dsum", i), 128'(a_sum), 128'(fill_dsum[i]));
            chk($sformatf("fill%0d.davg", i), 128'(a_avg), 128'(fill_davg[i]));
            chk($sformatf("fill%0d.fill", i), 128'(a_fill), 128'((i < 4) ? i + 1 : 4));
            chk($sformatf("fill%0d.primed", i), 128'(a_pr), 128'(i >= 3));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 64'hAA);
            chk("bubble.out_valid", 128'(a_ov), 128'd0);
            chk("bubble.dsum", 128'(a_sum), 128'd140);
        end
        step(1'b1, 1'b0, 64'd60);
        chk("after_bubble.dsum", 128'(a_sum), 128'd180);

        step(1'b1, 1'b1, 64'd99);
        chk("clr.dsum", 128'(a_sum), 128'd0);
        chk("clr.fill", 128'(a_fill), 128'd0);
        chk("clr.primed", 128'(a_pr), 128'd0);
        chk("clr.out_valid", 128'(a_ov), 128'd0);
        step(1'b1, 1'b0, 64'd7);
        chk("post_clr.dsum", 128'(a_sum), 128'd7);
        chk("post_clr.fill", 128'(a_fill), 128'd1);

        step(1'b0, 1'b1, 64'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, (i < 6) ? 64'hFF : 64'h0);
            chk($sformatf("max%0d.dsum", i), 128'(a_sum), 128'(max_dsum[i]));
            if (i >= 3 && i < 6) chk($sformatf("max%0d.davg", i), 128'(a_avg), 128'd255);
        end

        step(1'b1, 1'b0, 64'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst.dsum", 128'(a_sum), 128'd0);
        chk("async_rst.out_valid", 128'(a_ov), 128'd0);
        chk("async_rst.fill", 128'(a_fill), 128'd0);
        chk("async_rst.primed", 128'(a_pr), 128'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 64'd9);
        chk("post_rst.dsum", 128'(a_sum), 128'd9);
        chk("post_rst.fill", 128'(a_fill), 128'd1);

        for (int i = 0; i < 256; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 47) == 0), {$urandom(), $urandom()});
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, {$urandom(), $urandom()});
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/movavg_stream.md
Name: movavg_stream

Overview:
Parametrised streaming moving-sum / moving-average unit. It is the next generation of the fixed 64-bit, 4-tap combinational movavg block. Over the last N = 2^LOG2N accepted samples it produces a registered exact sum and a truncated average. It adds a valid qualifier, a window-fill indicator and a synchronous clear. A running-sum accumulator replaces the N-input adder tree, so adder cost does not grow with depth.

Parameters:
W, 64, sample width in bits (W >= 2)
LOG2N, 2, log2 of window depth N; legal range 1..8 (default N=4)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
clr  in  1  synchronous window clear, active-high
in_valid  in  1  din carries a sample this cycle
din  in  W  unsigned input sample
out_valid  out  1  dsum/davg updated at this edge
dsum  out  W+LOG2N  exact sum of the last N accepted samples
davg  out  W  dsum[W+LOG2N-1:LOG2N] (floor of sum/N)
primed  out  1  at least N samples accepted since reset/clr
fill  out  LOG2N+1  number of samples in window, saturates at N

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears history buf[0..N-1], sum, write pointer wptr, fill, out_valid, dsum, davg and primed to 0.
  - Deassertion is taken synchronously by the integrator's reset synchroniser, outside this block.
- Storage:
  - Circular buffer of N W-bit entries.
  - wptr is LOG2N bits and wraps N-1 -> 0 naturally.
  - Not-yet-written entries read as 0, so a partially filled window sums real samples plus zeros.
- Accept, rising edge with clr=0 and in_valid=1:
  - buf[wptr] <= din
  - sum <= sum + din - buf[wptr]
  - wptr <= wptr+1
  - fill <= min(fill+1, N)
  - out_valid <= 1
  - dsum <= new sum; davg <= new sum >> LOG2N
- Latency: exactly 1 cycle. A sample presented before edge k is reflected in dsum after edge k. No input backpressure: every valid sample is accepted.
- Idle, in_valid=0 and clr=0: sum, buf, wptr, fill, dsum, davg hold; out_valid <= 0.
- Clear, clr=1:
  - Has priority over in_valid; a coincident sample is dropped.
  - Next edge: all buf entries, sum, wptr, fill, dsum, davg and primed go to 0; out_valid <= 0.
- primed: registered; equals (fill == N) after each edge. Once set it stays 1 until clr or reset.
- Arithmetic:
  - Unsigned. sum is W+LOG2N bits; the sum of N W-bit values cannot overflow it.
  - The add/subtract is computed modulo 2^(W+LOG2N). Intermediate wrap cancels exactly, so dsum always equals the true window sum.
  - davg truncates; no rounding.
- Equivalence: with in_valid held 1 after reset and N=4, dsum[W-1:0] equals the legacy combinational movavg output one cycle later (the sum of the current and 3 previous samples).
- Timing: one W+LOG2N adder and one subtractor in series, register to register. Implementations may not add pipeline stages; latency is fixed at 1.

Test Plan:
- Fill/steady, W=8, LOG2N=2, in_valid=1, din=10,20,30,40,50:
  - dsum = 10,30,60,100,140
  - davg = 2,7,15,25,35
  - fill = 1,2,3,4,4
  - primed rises after the 4th sample
- Max values, W=8, LOG2N=2: din=255 for 6 cycles -> dsum=1020 (0x3FC) and davg=255 from the 4th output on, with no overflow. Then din=0 x4 -> dsum 765, 510, 255, 0.
- Bubbles: after the fill sequence, drop in_valid for 3 cycles -> out_valid=0 and dsum holds 140. Next sample 60 -> dsum = 140-20+60 = 180.
- Clear: after priming, assert clr together with in_valid and din=99 -> next edge dsum=0, fill=0, primed=0, out_valid=0. Next sample 7 -> dsum=7, fill=1.
- Async reset mid-stream: pull reset low between clock edges -> all outputs 0 immediately, without a clock edge. After release the window restarts from empty.
- Default W=64, LOG2N=2, 256 random 64-bit samples, in_valid randomly toggled -> dsum matches a scoreboard sum of the last 4 accepted samples on every out_valid cycle. Repeat with LOG2N=1 and LOG2N=5.
